// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types for the data-memory responder.
//   state_t   - responder FSM states
//   op_t      - decoded operation of a captured request
//   decode_op - classifies a request from its enables and address checks
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_LOAD,
        OP_STORE,
        OP_ERR
    } op_t;

    // Any address fault or a simultaneous load+store request is rejected.
    function automatic op_t decode_op(
        input logic we,
        input logic re,
        input logic misaligned,
        input logic out_of_range
    );
        if ((we && re) || misaligned || out_of_range) begin
            return OP_ERR;
        end else if (we) begin
            return OP_STORE;
        end else begin
            return OP_LOAD;
        end
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x N word array with synchronous active-low clear,
// one write port and one registered read port.
//   clk      in  : clock, rising edge
//   reset    in  : synchronous active-low; clears every word and rd_data
//   wr_en    in  : write wr_data to word wr_idx on this edge
//   wr_idx   in  : write word index
//   wr_data  in  : write data
//   rd_en    in  : capture word rd_idx into rd_data on this edge
//   rd_idx   in  : read word index
//   rd_data  out : registered read data; 0 on any edge without rd_en
module dmem_array #(
    parameter int N     = 64,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic [N-1:0]             wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [N-1:0]             rd_data
);

    logic [N-1:0] mem_q [DEPTH];
    logic [N-1:0] mem_d [DEPTH];
    logic [N-1:0] rd_data_q;
    logic [N-1:0] rd_data_d;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_idx] = wr_data;
        end
        // Returning zero when not reading lets the owner drive this straight out.
        rd_data_d = rd_en ? mem_q[rd_idx] : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            mem_q     <= mem_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the LEGv8 core.
// A request is captured in IDLE, waits LATENCY cycles in BUSY, and completes
// with a one-cycle DM_ready pulse in DONE. All outputs are registered.
//   clk            in  : clock, rising edge
//   reset          in  : synchronous active-low; aborts any access, clears memory
//   DM_addr        in  : byte address (must be 8-byte aligned, < DEPTH*8)
//   DM_writeData   in  : store data
//   DM_writeEnable in  : store request
//   DM_readEnable  in  : load request
//   DM_readData    out : load result, valid only while DM_ready=1 (else 0)
//   DM_ready       out : one-cycle completion pulse
//   DM_error       out : with DM_ready, request was rejected
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request; captures addr/data/op on acceptance
// BUSY  | wait states, cnt counts down; access performed when cnt==0
// DONE  | DM_ready high for this single cycle, then back to IDLE
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int N       = 64,
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] DM_addr,
    input  logic [N-1:0] DM_writeData,
    input  logic         DM_writeEnable,
    input  logic         DM_readEnable,
    output logic [N-1:0] DM_readData,
    output logic         DM_ready,
    output logic         DM_error
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [N-1:0] ADDR_LIMIT = N'(DEPTH * 8);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [N-1:0]  data_q, data_d;
    op_t           op_q, op_d;
    logic          ready_q, ready_d;
    logic          error_q, error_d;
    logic          arr_we;
    logic          arr_re;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        op_d    = op_q;
        ready_d = 1'b0;
        error_d = 1'b0;
        arr_we  = 1'b0;
        arr_re  = 1'b0;

        case (state_q)
            IDLE: begin
                if (DM_readEnable || DM_writeEnable) begin
                    idx_d   = DM_addr[AW+2:3];
                    data_d  = DM_writeData;
                    op_d    = decode_op(DM_writeEnable, DM_readEnable,
                                        |DM_addr[2:0], DM_addr >= ADDR_LIMIT);
                    cnt_d   = CNT_LOAD;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    // Access happens on the edge entering DONE so the result
                    // and the ready pulse appear together.
                    arr_we  = (op_q == OP_STORE);
                    arr_re  = (op_q == OP_LOAD);
                    ready_d = 1'b1;
                    error_d = (op_q == OP_ERR);
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                // Requests still held here are deliberately not sampled.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            op_q    <= OP_LOAD;
            ready_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            op_q    <= op_d;
            ready_q <= ready_d;
            error_q <= error_d;
        end
    end

    dmem_array #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (arr_we),
        .wr_idx  (idx_q),
        .wr_data (data_q),
        .rd_en   (arr_re),
        .rd_idx  (idx_q),
        .rd_data (DM_readData)
    );

    assign DM_ready = ready_q;
    assign DM_error = error_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

   logic        clk;
   logic        reset;
   logic [63:0] dm_addr;
   logic [63:0] dm_wdata;
   logic        dm_we;
   logic        dm_re;
   logic [63:0] rd_v [3];
   logic        rdy_v [3];
   logic        err_v [3];

   int n_checks;
   int n_err;

   int          lat;
   int          extra;
   logic [63:0] rd;
   logic        err;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   dmem_responder #(.N(64), .DEPTH(32), .LATENCY(2)) u_lat2 (
      .clk(clk), .reset(reset), .DM_addr(dm_addr), .DM_writeData(dm_wdata),
      .DM_writeEnable(dm_we), .DM_readEnable(dm_re),
      .DM_readData(rd_v[0]), .DM_ready(rdy_v[0]), .DM_error(err_v[0])
   );

   dmem_responder #(.N(64), .DEPTH(32), .LATENCY(1)) u_lat1 (
      .clk(clk), .reset(reset), .DM_addr(dm_addr), .DM_writeData(dm_wdata),
      .DM_writeEnable(dm_we), .DM_readEnable(dm_re),
      .DM_readData(rd_v[1]), .DM_ready(rdy_v[1]), .DM_error(err_v[1])
   );

   dmem_responder #(.N(64), .DEPTH(32), .LATENCY(4)) u_lat4 (
      .clk(clk), .reset(reset), .DM_addr(dm_addr), .DM_writeData(dm_wdata),
      .DM_writeEnable(dm_we), .DM_readEnable(dm_re),
      .DM_readData(rd_v[2]), .DM_ready(rdy_v[2]), .DM_error(err_v[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b0;
      dm_we    = 1'b0;
      dm_re    = 1'b0;
      dm_addr  = '0;
      dm_wdata = '0;
      step();
      step();
      reset = 1'b1;
   endtask

   task automatic req(input int sel, input logic we_i, input logic re_i,
                      input logic [63:0] a, input logic [63:0] d,
                      input bit hold, output int lat_o,
                      output logic [63:0] rd_o, output logic err_o,
                      output int extra_o);
      dm_we    = we_i;
      dm_re    = re_i;
      dm_addr  = a;
      dm_wdata = d;
      lat_o    = -1;
      rd_o     = 'x;
      err_o    = 1'bx;
      extra_o  = 0;
      for (int c = 1; c <= 20; c++) begin
         step();
         if (rdy_v[sel]) begin
            lat_o = c;
            rd_o  = rd_v[sel];
            err_o = err_v[sel];
            break;
         end
      end
      if (hold) step();
      dm_we = 1'b0;
      dm_re = 1'b0;
      if (!hold) step();
      if (hold) begin
         for (int c = 0; c < 8; c++) begin
            step();
            if (rdy_v[sel]) extra_o++;
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_err    = 0;

      do_reset();
      chk("reset_ready", rdy_v[0], 1'b0);
      chk("reset_error", err_v[0], 1'b0);
      chk("reset_rdata", rd_v[0], 64'h0);

      req(0, 1'b1, 1'b0, 64'h10, 64'hDEADBEEFCAFEF00D, 1'b0, lat, rd, err, extra);
      chk("store_latency", lat, 3);
      chk("store_error", err, 1'b0);
      chk("store_rdata", rd, 64'h0);
      chk("idle_ready_after_done", rdy_v[0], 1'b0);

      req(0, 1'b0, 1'b1, 64'h10, 64'h0, 1'b0, lat, rd, err, extra);
      chk("load_latency", lat, 3);
      chk("load_rdata", rd, 64'hDEADBEEFCAFEF00D);
      chk("load_error", err, 1'b0);

      req(0, 1'b0, 1'b1, 64'h0C, 64'h0, 1'b0, lat, rd, err, extra);
      chk("misal_latency", lat, 3);
      chk("misal_error", err, 1'b1);
      chk("misal_rdata", rd, 64'h0);
      req(0, 1'b0, 1'b1, 64'h10, 64'h0, 1'b0, lat, rd, err, extra);
      chk("misal_mem_intact", rd, 64'hDEADBEEFCAFEF00D);

      req(0, 1'b1, 1'b0, 64'h0, 64'h1111, 1'b0, lat, rd, err, extra);
      chk("w0_store_error", err, 1'b0);
      req(0, 1'b1, 1'b0, 64'h100, 64'hBAD, 1'b0, lat, rd, err, extra);
      chk("oor_error", err, 1'b1);
      chk("oor_rdata", rd, 64'h0);
      req(0, 1'b0, 1'b1, 64'h0, 64'h0, 1'b0, lat, rd, err, extra);
      chk("oor_w0_intact", rd, 64'h1111);

      req(0, 1'b1, 1'b1, 64'h0, 64'h2222, 1'b0, lat, rd, err, extra);
      chk("both_error", err, 1'b1);
      chk("both_rdata", rd, 64'h0);
      req(0, 1'b0, 1'b1, 64'h0, 64'h0, 1'b0, lat, rd, err, extra);
      chk("both_w0_intact", rd, 64'h1111);
      chk("both_load_error", err, 1'b0);

      dm_we    = 1'b1;
      dm_re    = 1'b0;
      dm_addr  = 64'h08;
      dm_wdata = 64'h1234;
      step();
      reset = 1'b0;
      dm_we = 1'b0;
      step();
      chk("abort_ready", rdy_v[0], 1'b0);
      chk("abort_error", err_v[0], 1'b0);
      chk("abort_rdata", rd_v[0], 64'h0);
      reset = 1'b1;
      extra = 0;
      for (int c = 0; c < 6; c++) begin
         step();
         if (rdy_v[0]) extra++;
      end
      chk("abort_no_pulse", extra, 0);
      req(0, 1'b0, 1'b1, 64'h08, 64'h0, 1'b0, lat, rd, err, extra);
      chk("abort_no_commit", rd, 64'h0);
      req(0, 1'b0, 1'b1, 64'h10, 64'h0, 1'b0, lat, rd, err, extra);
      chk("reset_cleared_mem", rd, 64'h0);

      do_reset();
      req(1, 1'b1, 1'b0, 64'h18, 64'hA5A5_0001_0203_0405, 1'b1, lat, rd, err, extra);
      chk("lat1_latency", lat, 2);
      chk("lat1_no_reaccept", extra, 0);
      req(1, 1'b0, 1'b1, 64'h18, 64'h0, 1'b0, lat, rd, err, extra);
      chk("lat1_load_latency", lat, 2);
      chk("lat1_load_rdata", rd, 64'hA5A5_0001_0203_0405);

      do_reset();
      req(2, 1'b1, 1'b0, 64'hF8, 64'h0F0E_0D0C_0B0A_0908, 1'b1, lat, rd, err, extra);
      chk("lat4_latency", lat, 5);
      chk("lat4_no_reaccept", extra, 0);
      req(2, 1'b0, 1'b1, 64'hF8, 64'h0, 1'b0, lat, rd, err, extra);
      chk("lat4_load_latency", lat, 5);
      chk("lat4_load_rdata", rd, 64'h0F0E_0D0C_0B0A_0908);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
